// File: rtl/key_shift_loader.sv
`default_nettype none
// ============================================================================
// Module      : key_shift_loader
// Description : Serial MSB-first loader for a 32-bit netlist unlock key.
//               Optional CRC-8 check with lockout, enabled by KEY_LOADER_CRC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module key_shift_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic        key_sen,
  input  logic        key_sdi,
  output logic [31:0] key_out,
  output logic        key_valid,
  output logic        key_busy,
  output logic        key_err,
  output logic        key_locked
);

`ifdef KEY_LOADER_CRC_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_CRC    = 3'd2,
    S_ARMED  = 3'd3,
    S_ERROR  = 3'd4,
    S_LOCKED = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_ARMED  = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
`endif

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [31:0] shadow;
  logic [31:0] shadow_next;

  assign shadow_next = {shadow[30:0], key_sdi};

`ifdef KEY_LOADER_CRC_EN
  logic [7:0] crc_calc;
  logic [7:0] crc_rx;
  logic [7:0] crc_calc_next;
  logic [7:0] crc_rx_next;
  logic [1:0] fail_cnt;

  // Serial CRC-8 (poly 0x07) fed MSB-first with each accepted key bit
  assign crc_calc_next = {crc_calc[6:0], 1'b0} ^ ({8{crc_calc[7] ^ key_sdi}} & 8'h07);
  assign crc_rx_next   = {crc_rx[6:0], key_sdi};
  assign key_busy      = (state == S_SHIFT) || (state == S_CRC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shadow     <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      key_err    <= 1'b0;
      key_locked <= 1'b0;
      crc_calc   <= '0;
      crc_rx     <= '0;
      fail_cnt   <= '0;
    end else if (key_start && (state != S_LOCKED)) begin
      state     <= S_SHIFT;
      bit_cnt   <= '0;
      shadow    <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      crc_calc  <= '0;
      crc_rx    <= '0;
    end else begin
      case (state)
        S_SHIFT: begin
          if (key_sen) begin
            shadow   <= shadow_next;
            crc_calc <= crc_calc_next;
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              state   <= S_CRC;
              bit_cnt <= '0;
            end
          end
        end
        S_CRC: begin
          if (key_sen) begin
            crc_rx  <= crc_rx_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              if (crc_rx_next == crc_calc) begin
                state     <= S_ARMED;
                key_out   <= shadow;
                key_valid <= 1'b1;
                key_err   <= 1'b0;
                fail_cnt  <= '0;
              end else if (fail_cnt == 2'd2) begin
                state      <= S_LOCKED;
                key_err    <= 1'b1;
                key_locked <= 1'b1;
                fail_cnt   <= fail_cnt + 2'd1;
              end else begin
                state    <= S_ERROR;
                key_err  <= 1'b1;
                fail_cnt <= fail_cnt + 2'd1;
              end
            end
          end
        end
        S_IDLE, S_ARMED, S_ERROR, S_LOCKED: begin
          state <= state;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign key_busy   = (state == S_SHIFT);
  assign key_err    = 1'b0;
  assign key_locked = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shadow    <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
    end else if (key_start) begin
      state     <= S_SHIFT;
      bit_cnt   <= '0;
      shadow    <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          if (key_sen) begin
            shadow  <= shadow_next;
            bit_cnt <= bit_cnt + 5'd1;
            // Last bit publishes the key on the same edge that samples it
            if (bit_cnt == 5'd31) begin
              state     <= S_ARMED;
              key_out   <= shadow_next;
              key_valid <= 1'b1;
            end
          end
        end
        S_IDLE, S_ARMED, S_ERROR: begin
          state <= state;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_shift_loader.sv
`default_nettype none
// Testbench for key_shift_loader: vector table, directed corner cases and
// randomized loads checked against a bit-queue reference model.
module tb_key_shift_loader;
  logic        clk = 1'b0;
  logic        rst, key_start, key_sen, key_sdi;
  logic [31:0] key_out;
  logic        key_valid, key_busy, key_err, key_locked;

  int total = 0;
  int bad   = 0;
  bit q[$];  // model: bits accepted since the most recent start

  always #5 clk = ~clk;

  key_shift_loader dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_sen(key_sen), .key_sdi(key_sdi),
    .key_out(key_out), .key_valid(key_valid), .key_busy(key_busy),
    .key_err(key_err), .key_locked(key_locked)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC-8 as polynomial long division of key*x^8 by x^8+x^2+x+1
  function automatic logic [7:0] crc8(input logic [31:0] k);
    logic [39:0] r;
    r = {k, 8'h00};
    for (int i = 39; i >= 8; i--)
      if (r[i]) r[i-:9] = r[i-:9] ^ 9'h107;
    return r[7:0];
  endfunction

  function automatic logic [31:0] model_key();
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < 32; i++)
      if (q[i]) v = v + (32'd1 << (31 - i));
    return v;
  endfunction

  task automatic start(input bit with_sen);
    key_start = 1'b1;
    key_sen   = with_sen;
    key_sdi   = 1'b1;
    tick();
    key_start = 1'b0;
    key_sen   = 1'b0;
    q.delete();
  endtask

  task automatic send_bit(input bit b);
    key_sen = 1'b1;
    key_sdi = b;
    tick();
    key_sen = 1'b0;
    q.push_back(b);
  endtask

  task automatic gap();
    key_sen = 1'b0;
    key_sdi = 1'($urandom);
    tick();
  endtask

  // Sends n key bits MSB-first, then (CRC build) the 8-bit check value
  task automatic send_word(input logic [31:0] k, input logic [7:0] crc, input int n,
                           input bit toggle, input int gap_pct);
    logic [31:0] kk;
    kk = k;
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) gap();
      while ($urandom_range(99) < gap_pct) gap();
      if (i == 31) begin
        chk("partial_out_hidden", key_out, 32'h0);
        chk("partial_valid_low", {31'd0, key_valid}, 32'd0);
      end
      send_bit(kk[31 - i]);
    end
`ifdef KEY_LOADER_CRC_EN
    if (n == 32) begin
      logic [7:0] cc;
      cc = crc;
      for (int i = 7; i >= 0; i--) begin
        while ($urandom_range(99) < gap_pct) gap();
        send_bit(cc[i]);
      end
    end
`else
    if (crc != 8'h00 && n != 32) gap();
`endif
  endtask

  typedef struct {
    logic [31:0] key;
    bit          toggle;
    int          gap_pct;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] k, held;
    rst = 1'b1; key_start = 1'b0; key_sen = 1'b0; key_sdi = 1'b0;
    tick(); tick();
    chk("reset_out", key_out, 32'h0);
    chk("reset_flags", {28'd0, key_valid, key_busy, key_err, key_locked}, 32'h0);
    rst = 1'b0;
    tick();

    vecs[0] = '{32'hA5A50F0F, 1'b0, 0,  32'hA5A50F0F};
    vecs[1] = '{32'hFFFFFFFF, 1'b1, 0,  32'hFFFFFFFF};
    vecs[2] = '{32'h00000000, 1'b0, 20, 32'h00000000};
    vecs[3] = '{32'h80000001, 1'b1, 0,  32'h80000001};
    vecs[4] = '{32'hDEADBEEF, 1'b0, 30, 32'hDEADBEEF};

    foreach (vecs[v]) begin
      start(1'b0);
      chk($sformatf("vec%0d_busy_after_start", v), {31'd0, key_busy}, 32'd1);
      send_word(vecs[v].key, crc8(vecs[v].key), 32, vecs[v].toggle, vecs[v].gap_pct);
      chk($sformatf("vec%0d_out", v), key_out, vecs[v].exp_out);
      chk($sformatf("vec%0d_flags", v), {28'd0, key_valid, key_busy, key_err, key_locked},
          32'h8);
      gap();
      chk($sformatf("vec%0d_out_hold", v), key_out, vecs[v].exp_out);
    end

    // ARMED ignores strobes, then reset from ARMED with 0xDEADBEEF loaded
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    chk("armed_ignores_sen", key_out, 32'hDEADBEEF);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("armed_reset_out", key_out, 32'h0);
    chk("armed_reset_valid", {31'd0, key_valid}, 32'd0);

    // Restart after 10 bits, with key_sen high on the restart edge
    start(1'b0);
    send_word(32'h12345678, 8'h00, 10, 1'b0, 0);
    start(1'b1);
    send_word(32'h00000003, crc8(32'h00000003), 32, 1'b0, 0);
    chk("restart_out", key_out, 32'h00000003);
    chk("restart_valid", {31'd0, key_valid}, 32'd1);

    // Reset mid-load discards bits; reset beats key_start
    start(1'b0);
    send_word(32'hFFFFFFFF, 8'h00, 12, 1'b0, 0);
    rst = 1'b1; key_start = 1'b1; tick(); rst = 1'b0; key_start = 1'b0;
    chk("rst_over_start_busy", {31'd0, key_busy}, 32'd0);
    start(1'b0);
    send_word(32'h0000A001, crc8(32'h0000A001), 32, 1'b0, 10);
    chk("after_midload_rst", key_out, 32'h0000A001);

    // Randomized loads, some abandoned mid-way, against the queue model
    for (int it = 0; it < 25; it++) begin
      start(1'($urandom));
      if ($urandom_range(2) == 0) begin
        send_word($urandom, 8'h00, $urandom_range(31, 1), 1'b0, 25);
        start(1'($urandom));
      end
      k = $urandom;
      send_word(k, crc8(k), 32, 1'($urandom), 30);
      held = model_key();
      chk($sformatf("rand%0d_out", it), key_out, held);
      chk($sformatf("rand%0d_valid", it), {31'd0, key_valid}, 32'd1);
    end

`ifdef KEY_LOADER_CRC_EN
    start(1'b0);
    send_word(32'h00000001, 8'h07, 32, 1'b0, 0);
    chk("crc_good_out", key_out, 32'h00000001);
    chk("crc_good_flags", {28'd0, key_valid, key_busy, key_err, key_locked}, 32'h8);
    for (int n = 1; n <= 3; n++) begin
      start(1'b0);
      send_word(32'h00000001, 8'h06, 32, 1'b0, 0);
      chk($sformatf("crc_bad%0d_out", n), key_out, 32'h0);
      chk($sformatf("crc_bad%0d_flags", n),
          {28'd0, key_valid, key_busy, key_err, key_locked}, (n == 3) ? 32'h3 : 32'h2);
    end
    start(1'b0);
    chk("locked_ignores_start", {28'd0, key_valid, key_busy, key_err, key_locked}, 32'h3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("locked_rst_out", key_out, 32'h0);
    chk("locked_rst_flags", {28'd0, key_valid, key_busy, key_err, key_locked}, 32'h0);
`else
    chk("no_crc_err_tied", {30'd0, key_err, key_locked}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/key_shift_loader.md
KEY_SHIFT_LOADER -- requirements
Module: key_shift_loader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port key_start, input, 1, begin a new key load (pulse).
REQ-004 SHALL have port key_sen, input, 1, serial-data-valid strobe; key_sdi is sampled only when key_sen=1.
REQ-005 SHALL have port key_sdi, input, 1, serial key data, MSB-first.
REQ-006 SHALL have port key_out, output, 32, key vector; bit i drives keyIn_0_i of the locked netlist.
REQ-007 SHALL have port key_valid, output, 1, key_out holds a complete accepted key.
REQ-008 SHALL have port key_busy, output, 1, a load is in progress (SHIFT or CRC state).
REQ-009 SHALL have port key_err, output, 1, the last load failed its check (ERROR or LOCKED state).
REQ-010 SHALL have port key_locked, output, 1, permanent lockout after repeated failures.
REQ-011 SHALL have one clock (clk), and reset SHALL be synchronous and active-high (rst).

Function
REQ-012 SHALL implement the states IDLE, SHIFT, CRC, ARMED, ERROR and LOCKED; CRC and LOCKED are reachable only when the macro is defined.
REQ-013 IDLE/ARMED/ERROR + key_start=1 -> SHIFT; bit counter=0, shadow register=0, key_valid=0, key_out=0 at that edge.
REQ-014 SHIFT: each edge with key_sen=1 -> shadow={shadow[30:0],key_sdi} and counter+1; key_sen=0 -> hold.
REQ-015 The first received bit SHALL land in key_out[31] and the 32nd received bit in key_out[0].
REQ-016 Without CRC, the edge sampling the 32nd bit -> ARMED, key_out=final shadow value, key_valid=1 at that same edge; there SHALL be zero added latency.
REQ-017 key_start during SHIFT/CRC SHALL restart the load, clearing the counter, shadow and CRC.
REQ-018 key_sen=1 coinciding with key_start SHALL be ignored; the restart wins and no bit is captured.
REQ-019 key_out SHALL be 0 whenever key_valid=0; a partial key SHALL never be exposed.
REQ-020 ARMED SHALL hold key_out stable indefinitely; key_sen is ignored in IDLE, ARMED, ERROR and LOCKED.
REQ-021 key_busy SHALL equal (state==SHIFT or CRC), combinational from state.

Reset
REQ-022 rst=1 at an edge -> IDLE, key_out=0, key_valid=0, key_busy=0, key_err=0, key_locked=0, counters=0, fail count=0; rst SHALL override key_start.
REQ-023 Reset mid-load SHALL discard all captured bits; the next load starts from bit 0.

Configuration
REQ-024 Macro KEY_LOADER_CRC_EN: when defined, after the 32nd key bit the state SHALL be CRC and 8 further key_sen bits SHALL be received (MSB-first) as the expected CRC.
REQ-025 CRC SHALL be CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over the 32 key bits in arrival order.
REQ-026 With the macro defined, the edge sampling the 8th CRC bit -> ARMED if match (key_valid=1, key_err=0), else ERROR (key_err=1, key_out=0).
REQ-027 With the macro defined, the 2-bit fail counter SHALL increment per mismatch and clear on a match; on the 3rd consecutive mismatch the state -> LOCKED (key_locked=1, key_err=1).
REQ-028 LOCKED SHALL ignore key_start, and only rst SHALL exit it.
REQ-029 With the macro undefined, the CRC logic, fail counter and CRC/LOCKED states SHALL be absent; key_err and key_locked SHALL be tied 0.

Verification
REQ-030 SHALL cover: no macro; key_start, then 32 bits of 0xA5A50F0F with key_sen=1 -> key_out=0xA5A50F0F, key_valid=1 on the 32nd sampling edge, key_busy=0.
REQ-031 SHALL cover: no macro; 0xFFFFFFFF loaded with key_sen toggling 1/0 every cycle -> exactly 32 strobes accepted, key_out=0xFFFFFFFF after 64 cycles.
REQ-032 SHALL cover: loading 0x12345678, reasserting key_start after 10 bits, then loading 0x00000003 -> key_out=0x00000003, with no residue from the first load.
REQ-033 SHALL cover: macro defined; key 0x00000001 + CRC 0x07 -> ARMED, key_out=0x00000001; key 0x00000001 + CRC 0x06 -> ERROR, key_out=0, key_err=1.
REQ-034 SHALL cover: macro defined; three consecutive bad loads -> key_locked=1, a further key_start is ignored, and rst -> all outputs 0, IDLE.
REQ-035 SHALL cover: rst asserted in ARMED with key_out=0xDEADBEEF -> next edge key_out=0, key_valid=0.
